// File: rtl/reg_wb_queue_if.sv
// Write-back bus between the execute/memory stages and reg_wb_queue.
// Handshake: a request transfers on a rising clk edge where valid and ready are both high; ready never depends on valid of the same port.
interface reg_wb_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
);
    logic                     alu_valid;
    logic                     alu_ready;
    logic [3:0]               alu_addr;
    logic [DW-1:0]            alu_data;
    logic                     alu_link;
    logic                     mem_valid;
    logic                     mem_ready;
    logic [3:0]               mem_addr;
    logic [DW-1:0]            mem_data;
    logic                     hold;
    logic                     reg_write;
    logic [3:0]               write_addr;
    logic [DW-1:0]            write_data;
    logic                     link;
    logic                     pc_load;
    logic [DW-1:0]            pc_data;
    logic [15:0]              busy_mask;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output alu_valid, alu_addr, alu_data, alu_link,
        output mem_valid, mem_addr, mem_data, hold,
        input  alu_ready, mem_ready, reg_write, write_addr, write_data,
        input  link, pc_load, pc_data, busy_mask, count
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, alu_link,
        input  mem_valid, mem_addr, mem_data, hold,
        output alu_ready, mem_ready, reg_write, write_addr, write_data,
        output link, pc_load, pc_data, busy_mask, count
    );
endinterface

// File: rtl/reg_wb_queue.sv
// Register-file write-back queue: ALU and load writes drained one per cycle, r15 diverted to pc_load.
// Define REG_WB_SCOREBOARD_EN to build the per-register pending counters behind busy_mask.
module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic           clk,
    input  logic           rst,
    reg_wb_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [3:0]    addr;
        logic [DW-1:0] data;
        logic          link;
    } entry_t;

    entry_t        fifo [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] alu_slot;
    logic [CW-1:0] count_q;
    logic          mem_ready;
    logic          alu_ready;
    logic          mem_acc;
    logic          alu_acc;
    logic          deq;
    entry_t        head;

    logic          reg_write_q;
    logic [3:0]    write_addr_q;
    logic [DW-1:0] write_data_q;
    logic          link_q;
    logic          pc_load_q;
    logic [DW-1:0] pc_data_q;

    // The ALU needs two free slots when a load arrives in the same cycle, since the load goes first.
    always_comb begin
        mem_ready = count_q < CW'(DEPTH);
        alu_ready = (count_q <= CW'(DEPTH - 2)) ||
                    ((count_q == CW'(DEPTH - 1)) && !bus.mem_valid);
        mem_acc   = bus.mem_valid && mem_ready;
        alu_acc   = bus.alu_valid && alu_ready;
        deq       = (count_q != '0) && !bus.hold;
        alu_slot  = mem_acc ? wr_ptr + AW'(1) : wr_ptr;
        head      = fifo[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (mem_acc) fifo[wr_ptr] <= '{addr: bus.mem_addr, data: bus.mem_data, link: 1'b0};
        if (alu_acc) fifo[alu_slot] <= '{addr: bus.alu_addr, data: bus.alu_data, link: bus.alu_link};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(mem_acc) + AW'(alu_acc);
            rd_ptr  <= rd_ptr + AW'(deq);
            count_q <= count_q + CW'(mem_acc) + CW'(alu_acc) - CW'(deq);
        end
    end

    // Address/data outputs hold their last value when idle; r15 writes only touch pc_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            link_q       <= 1'b0;
            pc_load_q    <= 1'b0;
            pc_data_q    <= '0;
        end else begin
            reg_write_q <= deq && (head.addr != 4'd15);
            pc_load_q   <= deq && (head.addr == 4'd15);
            link_q      <= deq && head.link;
            if (deq && head.addr != 4'd15) begin
                write_addr_q <= head.addr;
                write_data_q <= head.data;
            end
            if (deq && head.addr == 4'd15) pc_data_q <= head.data;
        end
    end

`ifdef REG_WB_SCOREBOARD_EN
    localparam int PW = $clog2(DEPTH + 2);

    logic [PW-1:0] pend      [16];
    logic [PW-1:0] pend_next [16];
    logic [3:0]    pres_addr;
    logic [15:0]   busy;

    // A pending write stays counted until its strobe cycle ends, not when it leaves the FIFO.
    always_comb begin
        busy = '0;
        for (int n = 0; n < 16; n++) begin
            pend_next[n] = pend[n]
                + PW'(mem_acc && (bus.mem_addr == 4'(n)))
                + PW'(alu_acc && (bus.alu_addr == 4'(n)))
                - PW'((reg_write_q || pc_load_q) && (pres_addr == 4'(n)));
            busy[n] = pend[n] != '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pres_addr <= '0;
            for (int n = 0; n < 16; n++) pend[n] <= '0;
        end else begin
            if (deq) pres_addr <= head.addr;
            for (int n = 0; n < 16; n++) pend[n] <= pend_next[n];
        end
    end

    assign bus.busy_mask = busy;
`else
    assign bus.busy_mask = 16'h0000;
`endif

    assign bus.mem_ready  = mem_ready;
    assign bus.alu_ready  = alu_ready;
    assign bus.count      = count_q;
    assign bus.reg_write  = reg_write_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;
    assign bus.link       = link_q;
    assign bus.pc_load    = pc_load_q;
    assign bus.pc_data    = pc_data_q;
endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: a cycle-by-cycle vector table plus an async-reset sequence.
module tb_reg_wb_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    reg_wb_queue_if #(.DEPTH(DEPTH), .DW(DW)) bus ();
    reg_wb_queue #(.DEPTH(DEPTH), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic mv; logic [3:0] ma; logic [31:0] md;
        logic av; logic [3:0] aa; logic [31:0] ad; logic al;
        logic h;
        logic emr; logic ear;
        logic erw; logic [3:0] ewa; logic [31:0] ewd;
        logic elk; logic epl; logic [31:0] epd;
        logic [2:0] ecnt; logic [15:0] ebusy;
    } vec_t;

    function automatic vec_t v(
        logic mv, logic [3:0] ma, logic [31:0] md,
        logic av, logic [3:0] aa, logic [31:0] ad, logic al, logic h,
        logic emr, logic ear, logic erw, logic [3:0] ewa, logic [31:0] ewd,
        logic elk, logic epl, logic [31:0] epd, logic [2:0] ecnt, logic [15:0] ebusy);
        vec_t r;
        r.mv = mv; r.ma = ma; r.md = md; r.av = av; r.aa = aa; r.ad = ad; r.al = al; r.h = h;
        r.emr = emr; r.ear = ear; r.erw = erw; r.ewa = ewa; r.ewd = ewd;
        r.elk = elk; r.epl = epl; r.epd = epd; r.ecnt = ecnt; r.ebusy = ebusy;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] busy_exp(input logic [15:0] m);
`ifdef REG_WB_SCOREBOARD_EN
        return m;
`else
        return (m & 16'h0000);
`endif
    endfunction

    task automatic drive(input logic mv, input logic [3:0] ma, input logic [31:0] md,
                         input logic av, input logic [3:0] aa, input logic [31:0] ad,
                         input logic al, input logic h);
        bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad; bus.alu_link = al;
        bus.hold = h;
    endtask

    // Scoreboard for the post-reset phase: every register write must match the expected queue.
    logic [35:0] exp_q[$];
    logic        mon_en = 1'b0;
    int          seen   = 0;

    always @(posedge clk) begin
        if (mon_en) begin
            #1;
            if (bus.pc_load) chk("stale_pc_load", 32'(bus.pc_load), 32'd0);
            if (bus.reg_write) begin
                seen++;
                if (exp_q.size() == 0) begin
                    chk("stale_write_addr", 32'(bus.write_addr), 32'hFFFF_FFFF);
                end else begin
                    logic [35:0] e;
                    e = exp_q.pop_front();
                    chk("sb_addr", 32'(bus.write_addr), 32'(e[35:32]));
                    chk("sb_data", bus.write_data, e[31:0]);
                end
            end
        end
    end

    vec_t tbl[$];

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_reg_write", 32'(bus.reg_write), 0);
        chk("rst_pc_load", 32'(bus.pc_load), 0);
        chk("rst_link", 32'(bus.link), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_busy", 32'(bus.busy_mask), 0);
        chk("rst_write_data", bus.write_data, 0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 1);
        chk("rst_alu_ready", 32'(bus.alu_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        //             mv ma  md       av aa  ad        al h   mr ar rw wa  wd       lk pl pd       cnt busy
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 0, 0,  0,       0, 0, 0,       0, 16'h0000));
        tbl.push_back(v(0, 0, 0,       1, 3,  32'hAA,   0, 0,  1, 1, 0, 0,  0,       0, 0, 0,       1, 16'h0008));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 1, 3,  32'hAA,  0, 0, 0,       0, 16'h0008));
        tbl.push_back(v(1, 1, 32'h11,  1, 2,  32'h22,   0, 0,  1, 1, 0, 3,  32'hAA,  0, 0, 0,       2, 16'h0006));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 1, 1,  32'h11,  0, 0, 0,       1, 16'h0006));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 1, 2,  32'h22,  0, 0, 0,       0, 16'h0004));
        tbl.push_back(v(0, 0, 0,       1, 15, 32'h100,  1, 0,  1, 1, 0, 2,  32'h22,  0, 0, 0,       1, 16'h8000));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 0, 2,  32'h22,  1, 1, 32'h100, 0, 16'h8000));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 0, 2,  32'h22,  0, 0, 32'h100, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0,       1, 4,  32'h44,   0, 1,  1, 1, 0, 2,  32'h22,  0, 0, 32'h100, 1, 16'h0010));
        tbl.push_back(v(0, 0, 0,       1, 5,  32'h55,   0, 1,  1, 1, 0, 2,  32'h22,  0, 0, 32'h100, 2, 16'h0030));
        tbl.push_back(v(0, 0, 0,       1, 6,  32'h66,   0, 1,  1, 1, 0, 2,  32'h22,  0, 0, 32'h100, 3, 16'h0070));
        tbl.push_back(v(0, 0, 0,       1, 7,  32'h77,   0, 1,  1, 1, 0, 2,  32'h22,  0, 0, 32'h100, 4, 16'h00F0));
        tbl.push_back(v(0, 0, 0,       1, 8,  32'h88,   0, 1,  0, 0, 0, 2,  32'h22,  0, 0, 32'h100, 4, 16'h00F0));
        tbl.push_back(v(0, 0, 0,       1, 8,  32'h88,   0, 0,  0, 0, 1, 4,  32'h44,  0, 0, 32'h100, 3, 16'h00F0));
        tbl.push_back(v(0, 0, 0,       1, 8,  32'h88,   0, 0,  1, 1, 1, 5,  32'h55,  0, 0, 32'h100, 3, 16'h01E0));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 1, 6,  32'h66,  0, 0, 32'h100, 2, 16'h01C0));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 1, 7,  32'h77,  0, 0, 32'h100, 1, 16'h0180));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 1, 8,  32'h88,  0, 0, 32'h100, 0, 16'h0100));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 0, 8,  32'h88,  0, 0, 32'h100, 0, 16'h0000));
        tbl.push_back(v(0, 0, 0,       1, 9,  32'h09,   0, 1,  1, 1, 0, 8,  32'h88,  0, 0, 32'h100, 1, 16'h0200));
        tbl.push_back(v(0, 0, 0,       1, 10, 32'h0A,   0, 1,  1, 1, 0, 8,  32'h88,  0, 0, 32'h100, 2, 16'h0600));
        tbl.push_back(v(0, 0, 0,       1, 11, 32'h0B,   0, 1,  1, 1, 0, 8,  32'h88,  0, 0, 32'h100, 3, 16'h0E00));
        tbl.push_back(v(1, 12, 32'h0C, 1, 13, 32'h0D,   0, 1,  1, 0, 0, 8,  32'h88,  0, 0, 32'h100, 4, 16'h1E00));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  0, 0, 1, 9,  32'h09,  0, 0, 32'h100, 3, 16'h1E00));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 1, 10, 32'h0A,  0, 0, 32'h100, 2, 16'h1C00));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 1, 11, 32'h0B,  0, 0, 32'h100, 1, 16'h1800));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 1, 12, 32'h0C,  0, 0, 32'h100, 0, 16'h1000));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 0, 12, 32'h0C,  0, 0, 32'h100, 0, 16'h0000));
        tbl.push_back(v(1, 5, 32'hA1,  1, 5,  32'hA2,   0, 0,  1, 1, 0, 12, 32'h0C,  0, 0, 32'h100, 2, 16'h0020));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 1,  1, 1, 0, 12, 32'h0C,  0, 0, 32'h100, 2, 16'h0020));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 1, 5,  32'hA1,  0, 0, 32'h100, 1, 16'h0020));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 1, 5,  32'hA2,  0, 0, 32'h100, 0, 16'h0020));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 0, 5,  32'hA2,  0, 0, 32'h100, 0, 16'h0000));
        tbl.push_back(v(1, 6, 32'hB1,  1, 7,  32'hB2,   0, 0,  1, 1, 0, 5,  32'hA2,  0, 0, 32'h100, 2, 16'h00C0));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 1, 6,  32'hB1,  0, 0, 32'h100, 1, 16'h00C0));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 1,  1, 1, 0, 6,  32'hB1,  0, 0, 32'h100, 1, 16'h0080));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 1, 7,  32'hB2,  0, 0, 32'h100, 0, 16'h0080));
        tbl.push_back(v(0, 0, 0,       0, 0,  0,        0, 0,  1, 1, 0, 7,  32'hB2,  0, 0, 32'h100, 0, 16'h0000));

        foreach (tbl[i]) begin
            vec_t t;
            t = tbl[i];
            @(negedge clk);
            drive(t.mv, t.ma, t.md, t.av, t.aa, t.ad, t.al, t.h);
            #1;
            chk($sformatf("v%0d_mem_ready", i), 32'(bus.mem_ready), 32'(t.emr));
            chk($sformatf("v%0d_alu_ready", i), 32'(bus.alu_ready), 32'(t.ear));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_reg_write", i), 32'(bus.reg_write), 32'(t.erw));
            chk($sformatf("v%0d_write_addr", i), 32'(bus.write_addr), 32'(t.ewa));
            chk($sformatf("v%0d_write_data", i), bus.write_data, t.ewd);
            chk($sformatf("v%0d_link", i), 32'(bus.link), 32'(t.elk));
            chk($sformatf("v%0d_pc_load", i), 32'(bus.pc_load), 32'(t.epl));
            chk($sformatf("v%0d_pc_data", i), bus.pc_data, t.epd);
            chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(t.ecnt));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy_mask), 32'(busy_exp(t.ebusy)));
        end

        // Async reset with entries queued and a strobe high.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 1, 4'(k + 1), 32'hD1 + 32'(k), 0, 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("pre_rst_reg_write", 32'(bus.reg_write), 1);
        chk("pre_rst_write_addr", 32'(bus.write_addr), 1);
        chk("pre_rst_count", 32'(bus.count), 3);
        chk("pre_rst_busy", 32'(bus.busy_mask), 32'(busy_exp(16'h001E)));
        #1;
        rst = 1'b1;
        #1;
        chk("arst_reg_write", 32'(bus.reg_write), 0);
        chk("arst_count", 32'(bus.count), 0);
        chk("arst_busy", 32'(bus.busy_mask), 0);
        chk("arst_write_addr", 32'(bus.write_addr), 0);
        chk("arst_write_data", bus.write_data, 0);
        chk("arst_pc_data", bus.pc_data, 0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        exp_q.push_back({4'd9, 32'h99});
        @(negedge clk);
        drive(0, 0, 0, 1, 9, 32'h99, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) @(negedge clk);
        mon_en = 1'b0;
        chk("post_rst_writes_seen", 32'(seen), 1);
        chk("post_rst_queue_empty", 32'(exp_q.size()), 0);
        chk("post_rst_count", 32'(bus.count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
